// File: rtl/scariv_inst_buf_queue.sv
// Instruction buffer between fetch/predecode and dispatch.
// Circular store of {pc, inst}. Fetch pushes up to FETCH_W contiguous slots.
// Dispatch sees up to DISP_W oldest entries and takes all of them, or none.
// A flush drops everything by resetting the pointers; storage is not cleared.

// One dispatch lane: selects entry (head + LANE) with an explicit wrap.
// Lanes at or beyond the presented count are driven to zero so idle lanes stay quiet.
module scariv_ibq_lane #(
  parameter int unsigned ENTRY_SIZE = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned DNUM_W     = 3,
  parameter int unsigned E_W        = 71,
  parameter int unsigned LANE       = 0
) (
  input  logic [ENTRY_SIZE-1:0][E_W-1:0] ents_i,
  input  logic [IDX_W-1:0]               head_i,
  input  logic [DNUM_W-1:0]              num_i,
  output logic [E_W-1:0]                 ent_o
);
  logic [IDX_W-1:0] idx;

  // Wrapped read index plus lane gating.
  always_comb begin
    int unsigned s;
    s = 32'(head_i) + LANE;
    if (s >= ENTRY_SIZE) s = s - ENTRY_SIZE;
    idx   = IDX_W'(s);
    ent_o = (DNUM_W'(LANE) < num_i) ? ents_i[idx] : '0;
  end
endmodule

module scariv_inst_buf_queue #(
  parameter int unsigned ENTRY_SIZE = 8,
  parameter int unsigned FETCH_W    = 4,
  parameter int unsigned DISP_W     = 5,
  parameter int unsigned PC_W       = 39
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush_valid,
  input  logic                          i_fetch_valid,
  output logic                          o_fetch_ready,
  input  logic [PC_W-1:0]               i_fetch_pc,
  input  logic [$clog2(FETCH_W+1)-1:0]  i_fetch_num,
  input  logic [FETCH_W*32-1:0]         i_fetch_inst,
  output logic                          o_disp_valid,
  output logic [$clog2(DISP_W+1)-1:0]   o_disp_num,
  output logic [DISP_W*PC_W-1:0]        o_disp_pc,
  output logic [DISP_W*32-1:0]          o_disp_inst,
  input  logic                          i_disp_ready
);
  localparam int unsigned IDX_W  = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;
  localparam int unsigned CNT_W  = $clog2(ENTRY_SIZE + 1);
  localparam int unsigned FNUM_W = $clog2(FETCH_W + 1);
  localparam int unsigned DNUM_W = $clog2(DISP_W + 1);
  localparam int unsigned E_W    = PC_W + 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } ent_t;

  ent_t [ENTRY_SIZE-1:0] ent_q, ent_d;
  logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      push_n, pop_n;
  logic                  push, pop;
  logic [DNUM_W-1:0]     disp_num;

  // Pointer advance; wraps explicitly because ENTRY_SIZE need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= ENTRY_SIZE) s = s - ENTRY_SIZE;
    return IDX_W'(s);
  endfunction

  // Ready and dispatch count look only at registered occupancy.
  assign o_fetch_ready = (CNT_W'(ENTRY_SIZE) - count_q) >= CNT_W'(FETCH_W);
  assign o_disp_valid  = (count_q != '0);
  assign disp_num      = (count_q > CNT_W'(DISP_W)) ? DNUM_W'(DISP_W) : DNUM_W'(count_q);
  assign o_disp_num    = disp_num;

  assign push   = i_fetch_valid & o_fetch_ready & ~i_flush_valid & (i_fetch_num != '0);
  assign pop    = o_disp_valid & i_disp_ready & ~i_flush_valid;
  assign push_n = push ? CNT_W'(i_fetch_num) : '0;
  assign pop_n  = pop ? CNT_W'(disp_num) : '0;

  // Pointer and count update; flush overrides any push/pop this cycle.
  always_comb begin
    head_d  = wrap_add(head_q, 32'(pop_n));
    tail_d  = wrap_add(tail_q, 32'(push_n));
    count_d = count_q + push_n - pop_n;
    if (i_flush_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Storage write: slot k lands at tail+k (wrapped) with PC advanced by 4 per slot.
  always_comb begin
    ent_d = ent_q;
    if (push) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (FNUM_W'(k) < i_fetch_num) begin
          ent_d[wrap_add(tail_q, k)] = '{pc:   i_fetch_pc + PC_W'(4 * k),
                                         inst: i_fetch_inst[32*k +: 32]};
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ent_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  // Dispatch lanes, one reader per lane.
  logic [DISP_W-1:0][E_W-1:0]  lane_ent;
  logic [DISP_W-1:0][PC_W-1:0] lane_pc;
  logic [DISP_W-1:0][31:0]     lane_inst;

  for (genvar j = 0; j < DISP_W; j++) begin : g_lane
    scariv_ibq_lane #(
      .ENTRY_SIZE(ENTRY_SIZE), .IDX_W(IDX_W), .DNUM_W(DNUM_W), .E_W(E_W), .LANE(j)
    ) u_lane (
      .ents_i (ent_q),
      .head_i (head_q),
      .num_i  (disp_num),
      .ent_o  (lane_ent[j])
    );
    assign lane_pc[j]   = lane_ent[j][E_W-1:32];
    assign lane_inst[j] = lane_ent[j][31:0];
  end

  assign o_disp_pc   = lane_pc;
  assign o_disp_inst = lane_inst;

`ifndef SYNTHESIS
  // Occupancy and request sanity.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (count_q <= CNT_W'(ENTRY_SIZE)) else $error("ibq: count overflow");
      assert (pop_n <= count_q) else $error("ibq: pop exceeds count");
      assert (!(i_fetch_valid && i_fetch_num > FNUM_W'(FETCH_W)))
        else $error("ibq: fetch_num exceeds FETCH_W");
    end
  end
`endif
endmodule

// File: tb/tb_scariv_inst_buf_queue.sv
// Bench for scariv_inst_buf_queue: directed plan then random traffic,
// checked against a queue model of the buffer contents.
module tb_scariv_inst_buf_queue;
  localparam int E = 8, F = 4, D = 5, P = 39;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic            i_reset_n, i_flush_valid, i_fetch_valid, i_disp_ready;
  logic            o_fetch_ready, o_disp_valid;
  logic [P-1:0]    i_fetch_pc;
  logic [2:0]      i_fetch_num;
  logic [F*32-1:0] i_fetch_inst;
  logic [2:0]      o_disp_num;
  logic [D*P-1:0]  o_disp_pc;
  logic [D*32-1:0] o_disp_inst;

  scariv_inst_buf_queue #(.ENTRY_SIZE(E), .FETCH_W(F), .DISP_W(D), .PC_W(P)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush_valid(i_flush_valid),
    .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
    .i_fetch_pc(i_fetch_pc), .i_fetch_num(i_fetch_num), .i_fetch_inst(i_fetch_inst),
    .o_disp_valid(o_disp_valid), .o_disp_num(o_disp_num), .o_disp_pc(o_disp_pc),
    .o_disp_inst(o_disp_inst), .i_disp_ready(i_disp_ready)
  );

  typedef struct {
    logic [P-1:0] pc;
    logic [31:0]  inst;
  } me_t;
  me_t mq[$];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model; only presented lanes are checked for data.
  task automatic check_outputs(input string tag);
    int sz, n;
    logic [D*P-1:0]  epc, mpc;
    logic [D*32-1:0] ein, min_;
    sz = mq.size();
    n  = (sz > D) ? D : sz;
    epc = '0; mpc = '0; ein = '0; min_ = '0;
    for (int j = 0; j < n; j++) begin
      epc[j*P +: P]   = mq[j].pc;
      mpc[j*P +: P]   = '1;
      ein[j*32 +: 32] = mq[j].inst;
      min_[j*32 +: 32] = '1;
    end
    chk({tag, ".ready"}, 256'(o_fetch_ready), 256'((E - sz) >= F));
    chk({tag, ".valid"}, 256'(o_disp_valid), 256'(sz != 0));
    chk({tag, ".num"},   256'(o_disp_num), 256'(n));
    chk({tag, ".pc"},    256'(o_disp_pc & mpc), 256'(epc));
    chk({tag, ".inst"},  256'(o_disp_inst & min_), 256'(ein));
  endtask

  // One clock: drive, check pre-edge outputs, advance the model, cross the edge.
  task automatic cyc(input string tag, input logic fv, input int fnum, input logic [P-1:0] pc,
                     input logic [F*32-1:0] inst, input logic dr, input logic fl);
    int sz;
    bit rdy;
    i_fetch_valid = fv; i_fetch_num = 3'(fnum); i_fetch_pc = pc;
    i_fetch_inst = inst; i_disp_ready = dr; i_flush_valid = fl;
    #3;
    check_outputs(tag);
    sz  = mq.size();
    rdy = (E - sz) >= F;
    if (fl) mq.delete();
    else begin
      if (dr && sz > 0) repeat ((sz > D) ? D : sz) void'(mq.pop_front());
      if (fv && rdy && fnum != 0)
        for (int k = 0; k < fnum; k++) mq.push_back('{pc + P'(4 * k), inst[32*k +: 32]});
    end
    @(posedge i_clk); #1;
  endtask

  function automatic logic [F*32-1:0] rinst();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, ".ready"}, 256'(o_fetch_ready), 256'(1));
    chk({tag, ".valid"}, 256'(o_disp_valid), 256'(0));
    chk({tag, ".num"},   256'(o_disp_num), 256'(0));
    chk({tag, ".pc"},    256'(o_disp_pc), 256'(0));
    chk({tag, ".inst"},  256'(o_disp_inst), 256'(0));
  endtask

  initial begin
    i_reset_n = 1'b0; i_flush_valid = 0; i_fetch_valid = 0; i_disp_ready = 0;
    i_fetch_pc = '0; i_fetch_num = '0; i_fetch_inst = '0;
    repeat (3) @(posedge i_clk);
    #2;
    reset_checks("rst_hold");
    @(negedge i_clk); i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    reset_checks("rst_rel");

    // Fill to full, then drain in two dispatch groups.
    cyc("push1",  1, 4, 39'h1000, rinst(), 0, 0);
    cyc("push2",  1, 4, 39'h2000, rinst(), 0, 0);
    cyc("full",   1, 4, 39'h9000, rinst(), 1, 0);  // rejected: not ready
    cyc("pop2",   0, 0, 39'h0,    rinst(), 1, 0);
    cyc("empty",  0, 0, 39'h0,    rinst(), 1, 0);

    // Simultaneous push and pop at count 4.
    cyc("sp_a",   1, 4, 39'h3000, rinst(), 0, 0);
    cyc("sp_b",   1, 4, 39'h3100, rinst(), 1, 0);
    cyc("sp_c",   0, 0, 39'h0,    rinst(), 1, 0);
    cyc("sp_d",   1, 0, 39'h7777, rinst(), 0, 0);  // num=0 is a no-op

    // Wrap-around with interleaved pops.
    cyc("wr_a",   1, 3, 39'h4000, rinst(), 0, 0);
    cyc("wr_b",   0, 0, 39'h0,    rinst(), 1, 0);
    cyc("wr_c",   1, 4, 39'h5000, rinst(), 0, 0);
    cyc("wr_d",   1, 4, 39'h6000, rinst(), 0, 0);
    cyc("wr_e",   1, 4, 39'h6100, rinst(), 1, 0);
    cyc("wr_f",   1, 2, 39'h6200, rinst(), 1, 0);
    cyc("wr_g",   0, 0, 39'h0,    rinst(), 1, 0);
    cyc("wr_h",   0, 0, 39'h0,    rinst(), 1, 0);

    // Flush with concurrent push and pop at count 6.
    cyc("fl_a",   1, 4, 39'h7000, rinst(), 0, 0);
    cyc("fl_b",   1, 2, 39'h7100, rinst(), 0, 0);
    cyc("fl_c",   1, 4, 39'h7200, rinst(), 1, 1);
    cyc("fl_d",   0, 0, 39'h0,    rinst(), 1, 0);
    cyc("fl_e",   1, 1, 39'h7300, rinst(), 0, 0);
    cyc("fl_f",   0, 0, 39'h0,    rinst(), 0, 0);

    // PC truncation at the top of the address space.
    cyc("pc_top", 1, 4, 39'h7f_ffff_fff8, rinst(), 1, 0);
    cyc("pc_wr",  0, 0, 39'h0, rinst(), 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", 1'($urandom_range(0, 3) != 0), $urandom_range(0, F),
          P'({$urandom, $urandom}) & ~P'(3), rinst(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    // Asynchronous reset mid-operation.
    cyc("pre_ar", 1, 4, 39'h8000, rinst(), 0, 0);
    i_fetch_valid = 0; i_disp_ready = 0;
    i_reset_n = 1'b0;
    #2;
    mq.delete();
    reset_checks("async_rst");
    #3 i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    cyc("post_ar", 1, 2, 39'h8800, rinst(), 0, 0);
    cyc("post_ar2", 0, 0, 39'h0, rinst(), 1, 0);
    cyc("post_ar3", 0, 0, 39'h0, rinst(), 0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
